// File: rtl/life_gen_sequencer.sv
// rtl/life_gen_sequencer.sv - command sequencer pacing Game-of-Life generations and host cell access
module life_gen_sequencer #(
  parameter int X_BITS     = 6,
  parameter int Y_BITS     = 6,
  parameter int CMD_BITS   = 2,
  parameter int STATE_BITS = 1,
  parameter int CMD_NOP    = 0,
  parameter int CMD_WRITE  = 1,
  parameter int CMD_READ   = 2,
  parameter int CMD_STEP   = 3,
  parameter int READ_LAT   = 2,
  parameter int SETTLE     = 2,
  parameter int PERIOD     = 100000000,
  parameter int GEN_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  step,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [X_BITS-1:0]     host_x,
  input  logic [Y_BITS-1:0]     host_y,
  input  logic [STATE_BITS-1:0] host_wdata,
  output logic                  host_ack,
  output logic [STATE_BITS-1:0] host_rdata,
  output logic [CMD_BITS-1:0]   arr_cmd,
  output logic [X_BITS-1:0]     arr_x,
  output logic [Y_BITS-1:0]     arr_y,
  output logic [STATE_BITS-1:0] arr_din,
  input  logic [STATE_BITS-1:0] arr_dout,
  output logic [GEN_BITS-1:0]   gen_count,
  output logic                  busy,
  output logic                  overrun
);

  localparam logic [CMD_BITS-1:0] C_NOP   = CMD_BITS'(CMD_NOP);
  localparam logic [CMD_BITS-1:0] C_WRITE = CMD_BITS'(CMD_WRITE);
  localparam logic [CMD_BITS-1:0] C_READ  = CMD_BITS'(CMD_READ);
  localparam logic [CMD_BITS-1:0] C_STEP  = CMD_BITS'(CMD_STEP);
  localparam int CNT_W = $clog2(PERIOD);
  localparam int LAT_W = $clog2(READ_LAT + 1);
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_WAIT, S_STEP, S_SETTLE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [SET_W-1:0]      set_q, set_d;
  logic                  pend_q, pend_d;
  logic                  ovr_q, ovr_d;
  logic                  ack_q, ack_d;
  logic                  busy_q, busy_d;
  logic [STATE_BITS-1:0] rdata_q, rdata_d;
  logic [CMD_BITS-1:0]   cmd_q, cmd_d;
  logic [X_BITS-1:0]     x_q, x_d;
  logic [Y_BITS-1:0]     y_q, y_d;
  logic [STATE_BITS-1:0] din_q, din_d;
  logic [GEN_BITS-1:0]   gen_q, gen_d;
  logic                  trig;
  logic                  consume;

  // Period counter and trigger: free-running in run mode, step pulses otherwise
  always_comb begin
    cnt_d = '0;
    trig  = 1'b0;
    if (run) begin
      if (cnt_q == CNT_W'(PERIOD - 1)) begin
        trig = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      trig = step;
    end
  end

  // Sequencer next-state and registered-output values
  always_comb begin
    state_d = state_q;
    cmd_d   = C_NOP;
    x_d     = x_q;
    y_d     = y_q;
    din_d   = din_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    gen_d   = gen_q;
    lat_d   = lat_q;
    set_d   = set_q;
    consume = 1'b0;
    case (state_q)
      S_IDLE: begin
        // the ack cycle must not re-serve the request the host is still dropping
        if (host_req && !ack_q) begin
          x_d = host_x;
          y_d = host_y;
          if (host_we) begin
            state_d = S_WR;
            cmd_d   = C_WRITE;
            din_d   = host_wdata;
          end else begin
            state_d = S_RD_WAIT;
            cmd_d   = C_READ;
            lat_d   = '0;
          end
        end else if (pend_q) begin
          consume = 1'b1;
          state_d = S_STEP;
          cmd_d   = C_STEP;
        end
      end
      S_WR: begin
        state_d = S_IDLE;
        ack_d   = 1'b1;
      end
      S_RD_WAIT: begin
        if (lat_q == LAT_W'(READ_LAT)) begin
          rdata_d = arr_dout;
          ack_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_STEP: begin
        if (SETTLE == 0) begin
          state_d = S_IDLE;
          gen_d   = gen_q + 1'b1;
        end else begin
          state_d = S_SETTLE;
          set_d   = '0;
        end
      end
      S_SETTLE: begin
        if (set_q == SET_W'(SETTLE - 1)) begin
          state_d = S_IDLE;
          gen_d   = gen_q + 1'b1;
        end else begin
          set_d = set_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    // a single pending slot; a trigger that finds it occupied is dropped and flagged
    pend_d = consume ? 1'b0 : (trig ? 1'b1 : pend_q);
    ovr_d  = ovr_q | (trig & pend_q);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
      set_q   <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
      cmd_q   <= C_NOP;
      x_q     <= '0;
      y_q     <= '0;
      din_q   <= '0;
      gen_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      set_q   <= set_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
      cmd_q   <= cmd_d;
      x_q     <= x_d;
      y_q     <= y_d;
      din_q   <= din_d;
      gen_q   <= gen_d;
    end
  end

  assign host_ack   = ack_q;
  assign host_rdata = rdata_q;
  assign arr_cmd    = cmd_q;
  assign arr_x      = x_q;
  assign arr_y      = y_q;
  assign arr_din    = din_q;
  assign gen_count  = gen_q;
  assign busy       = busy_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_life_gen_sequencer.sv
// tb/tb_life_gen_sequencer.sv - directed self-checking bench for life_gen_sequencer
module tb_life_gen_sequencer;

  localparam int GB = 4;

  logic          clk = 1'b0;
  logic          rst, run, step, host_req, host_we, host_wdata;
  logic [5:0]    host_x, host_y;
  logic          host_ack, host_rdata;
  logic [1:0]    arr_cmd;
  logic [5:0]    arr_x, arr_y;
  logic          arr_din;
  logic          arr_dout = 1'b0;
  logic [GB-1:0] gen_count;
  logic          busy, overrun;

  int checks   = 0;
  int failures = 0;

  life_gen_sequencer #(
    .X_BITS(6), .Y_BITS(6), .CMD_BITS(2), .STATE_BITS(1),
    .READ_LAT(2), .SETTLE(2), .PERIOD(8), .GEN_BITS(GB)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .step(step),
    .host_req(host_req), .host_we(host_we), .host_x(host_x), .host_y(host_y),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .arr_cmd(arr_cmd), .arr_x(arr_x), .arr_y(arr_y), .arr_din(arr_din),
    .arr_dout(arr_dout), .gen_count(gen_count), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // array model: writes land immediately, read data appears two cycles after CMD_READ
  logic mem [0:4095];
  logic rd_s1 = 1'b0;
  always @(posedge clk) begin
    if (arr_cmd == 2'd1) mem[{arr_y, arr_x}] <= arr_din;
    rd_s1    <= (arr_cmd == 2'd2) ? mem[{arr_y, arr_x}] : 1'b0;
    arr_dout <= rd_s1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [5:0] seen_x, seen_y;
  logic       seen_din;

  task automatic host_access(input logic we, input logic [5:0] x, input logic [5:0] y, input logic d,
                             output int cmd_cyc, output logic [1:0] cmd, output int ack_cyc, output logic rd);
    host_req = 1'b1; host_we = we; host_x = x; host_y = y; host_wdata = d;
    cmd_cyc = -1; ack_cyc = -1; cmd = 2'd0; rd = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick(1);
      if (arr_cmd != 2'd0 && cmd_cyc < 0) begin
        cmd_cyc = n; cmd = arr_cmd; seen_x = arr_x; seen_y = arr_y; seen_din = arr_din;
      end
      if (host_ack) begin
        ack_cyc = n; rd = host_rdata;
        break;
      end
    end
    host_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cc, ac, bad, nst;
    logic [1:0] cm;
    logic rdv;
    logic [1:0] hist [0:47];
    rst = 1'b1; run = 1'b0; step = 1'b0; host_req = 1'b0; host_we = 1'b0;
    host_x = '0; host_y = '0; host_wdata = 1'b0;
    tick(3);
    check("rst_cmd", arr_cmd, 0);
    check("rst_busy", busy, 0);
    check("rst_gen", gen_count, 0);
    check("rst_ack", host_ack, 0);
    rst = 1'b0;

    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (arr_cmd != 2'd0 || busy || overrun) bad++;
    end
    check("idle_quiet", bad, 0);
    check("idle_gen", gen_count, 0);

    host_access(1'b1, 6'd5, 6'd3, 1'b1, cc, cm, ac, rdv);
    check("wr_cmd", cm, 1);
    check("wr_x", seen_x, 5);
    check("wr_y", seen_y, 3);
    check("wr_din", seen_din, 1);
    check("wr_cmd_cyc", cc, 1);
    check("wr_ack_lat", ac - cc, 1);
    host_access(1'b0, 6'd5, 6'd3, 1'b0, cc, cm, ac, rdv);
    check("rd_cmd", cm, 2);
    check("rd_x", seen_x, 5);
    check("rd_y", seen_y, 3);
    check("rd_ack_lat", ac - cc, 3);
    check("rd_data", rdv, 1);
    tick(1);
    check("rd_ack_pulse", host_ack, 0);
    check("rd_data_held", host_rdata, 1);

    for (int i = 0; i < 48; i++) begin
      if (i == 0) run = 1'b1;
      if (i == 40) run = 1'b0;
      tick(1);
      hist[i] = arr_cmd;
    end
    bad = 0; nst = 0;
    for (int i = 0; i < 48; i++) begin
      if (hist[i] == 2'd3) nst++;
      if (i >= 8 && i <= 40 && (i % 8) == 0) begin
        if (hist[i] != 2'd3) bad++;
      end else if (hist[i] != 2'd0) bad++;
    end
    check("run_pattern", bad, 0);
    check("run_steps", nst, 5);
    check("run_gen", gen_count, 5);
    check("run_overrun", overrun, 0);

    step = 1'b1;
    nst = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) step = 1'b0;
      tick(1);
      if (arr_cmd == 2'd3) nst++;
    end
    check("dbl_steps", nst, 1);
    check("dbl_gen", gen_count, 6);
    check("dbl_overrun", overrun, 1);

    host_req = 1'b1; host_we = 1'b1; host_x = 6'd7; host_y = 6'd9; host_wdata = 1'b1; step = 1'b1;
    tick(1);
    step = 1'b0;
    check("pri_wr", arr_cmd, 1);
    tick(1);
    check("pri_ack", host_ack, 1);
    host_req = 1'b0;
    tick(1);
    check("pri_step", arr_cmd, 3);
    tick(4);
    check("pri_gen", gen_count, 7);
    check("pri_overrun_sticky", overrun, 1);

    host_req = 1'b1; host_we = 1'b0; host_x = 6'd5; host_y = 6'd3;
    tick(1);
    check("abort_read", arr_cmd, 2);
    tick(1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_cmd", arr_cmd, 0);
    check("abort_ack", host_ack, 0);
    check("abort_busy", busy, 0);
    check("abort_gen", gen_count, 0);
    check("abort_overrun", overrun, 0);
    host_req = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (host_ack) bad++;
    end
    check("abort_no_ack", bad, 0);
    rst = 1'b0;
    tick(1);
    host_access(1'b0, 6'd5, 6'd3, 1'b0, cc, cm, ac, rdv);
    check("post_rd_lat", ac - cc, 3);
    check("post_rd_data", rdv, 1);

    for (int k = 1; k <= 16; k++) begin
      step = 1'b1;
      tick(1);
      step = 1'b0;
      tick(6);
      if (k == 15) check("wrap_max", gen_count, 15);
    end
    check("wrap_zero", gen_count, 0);
    check("wrap_overrun", overrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/life_gen_sequencer.md
Name: life_gen_sequencer

Overview:
- Parametrised command sequencer for the Game-of-Life PE array. Replaces the free-running timer and raw opcode inputs at the array boundary.
- Arbitrates host cell read/write requests against generation steps, and issues all array opcodes and addresses.
- Paces evolution with an internal period counter (run mode) or single-step pulses.
- Tracks the generation count and flags overrun of the generation period.

Parameters:
- X_BITS, 6, array column address width
- Y_BITS, 6, array row address width
- CMD_BITS, 2, array opcode width
- STATE_BITS, 1, PE state width
- CMD_NOP, 0, array idle opcode
- CMD_WRITE, 1, array cell write opcode
- CMD_READ, 2, array cell read opcode
- CMD_STEP, 3, array compute-next-generation opcode
- READ_LAT, 2, cycles from CMD_READ to valid state_out (>=1)
- SETTLE, 2, NOP cycles after CMD_STEP before next command (>=0)
- PERIOD, 100000000, clk cycles between automatic generations (>=2)
- GEN_BITS, 16, generation counter width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- run  in  1  level; 1 = automatic evolution every PERIOD cycles
- step  in  1  single-cycle pulse; request one generation when run=0
- host_req  in  1  host access request, held until host_ack
- host_we  in  1  1 = write, 0 = read; sampled with host_req
- host_x  in  X_BITS  host cell column
- host_y  in  Y_BITS  host cell row
- host_wdata  in  STATE_BITS  write data
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  STATE_BITS  read data, valid while host_ack=1, held afterwards
- arr_cmd  out  CMD_BITS  opcode to array
- arr_x  out  X_BITS  address to array
- arr_y  out  Y_BITS  address to array
- arr_din  out  STATE_BITS  write data to array
- arr_dout  in  STATE_BITS  read data from array
- gen_count  out  GEN_BITS  completed generations, wraps modulo 2^GEN_BITS
- busy  out  1  1 whenever FSM is not IDLE
- overrun  out  1  sticky; a trigger arrived while a generation was already pending

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; arr_cmd=CMD_NOP; arr_x, arr_y, arr_din, host_rdata, gen_count = 0; host_ack, busy, overrun = 0; period counter = 0; gen_pending = 0. Reset mid-operation aborts it with no ack.
- All outputs are registered.
- Period counter:
  - Increments only while run=1; run=0 clears it to 0.
  - On reaching PERIOD-1 it wraps to 0 and raises trigger.
  - step with run=0 raises trigger; step with run=1 is ignored.
- Trigger sets gen_pending. A trigger while gen_pending=1 (or the same cycle it is consumed) sets overrun; triggers never queue beyond one.
- FSM states: IDLE, WR, RD_WAIT, STEP, SETTLE.
- IDLE priority: host_req first, then gen_pending.
  - host_req & host_we -> WR.
  - host_req & !host_we -> RD_WAIT.
  - gen_pending -> STEP, clearing gen_pending.
  - Host therefore never waits more than one generation.
- WR (1 cycle): arr_cmd=CMD_WRITE, arr_x/arr_y/arr_din = host fields. Next cycle: host_ack=1, -> IDLE.
- RD_WAIT:
  - First cycle arr_cmd=CMD_READ with address; then CMD_NOP with address held.
  - After READ_LAT cycles, capture arr_dout into host_rdata, host_ack=1, -> IDLE.
- STEP (1 cycle): arr_cmd=CMD_STEP. -> SETTLE, or straight to IDLE if SETTLE=0.
- SETTLE: CMD_NOP for SETTLE cycles. gen_count increments on exit to IDLE.
- Ack timing: host_ack is asserted in the cycle the FSM is back in IDLE. The host must drop host_req in that cycle; the FSM ignores host_req during the ack cycle to prevent double service.
- arr_cmd is CMD_NOP in every state/cycle not listed above.
- The period counter keeps running during host accesses. A generation delayed by host traffic does not shift the next period boundary.

Test Plan (PERIOD=8, READ_LAT=2, SETTLE=2 unless stated):
- Reset, run=0, no requests, 50 cycles -> arr_cmd=0 throughout, gen_count=0, busy=0, overrun=0.
- Host write (x=5, y=3, d=1), then host read at the same address -> write: CMD_WRITE one cycle with x=5, y=3, din=1, ack 1 cycle later. Read: CMD_READ, ack 3 cycles after the READ cycle, host_rdata equals the modelled arr_dout (1).
- run=1 for 40 cycles -> CMD_STEP exactly every 8 cycles (5 steps), each followed by 2 NOPs; gen_count=5; overrun=0.
- run=0, step pulse, then a second step pulse 1 cycle later (before STEP issues) -> one CMD_STEP, gen_count+1, overrun=1 held until reset.
- host_req and trigger in the same cycle -> host access served first, then CMD_STEP immediately after the ack cycle; gen_count+1.
- Assert rst during RD_WAIT -> no host_ack, arr_cmd=0 in the reset cycle, all counters 0. After release, a new read completes normally. Also preload gen_count to 0xFFFF and step once -> wraps to 0.
